// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the register-file write-port arbiter.
//   NUM_WR_REQ       number of requesters sharing the write port
//   REQ_WB/LD/DBG    requester indices (writeback, load return, debug loader)
//   REG_ZERO/REG_PC  architecturally special register addresses
//   arb_state_t      arbiter FSM states
//   onehot_to_idx    encode a 3-bit one-hot grant into a requester index
package regfile_pkg;

  localparam int NUM_WR_REQ = 3;
  localparam int REQ_WB     = 0;
  localparam int REQ_LD     = 1;
  localparam int REQ_DBG    = 2;

  localparam logic [3:0] REG_ZERO = 4'd0;
  localparam logic [3:0] REG_PC   = 4'd15;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// rr_pick3: combinational three-way picker.
//   req     [2:0]  eligible requests (already masked for stall/lock)
//   ptr     [1:0]  index of the last granted requester
//   starved [2:0]  requesters whose wait counter is saturated
//   pick    [2:0]  one-hot winner, zero when nothing is eligible
// A starved, requesting index beats everything (lowest index first);
// otherwise the search starts just after ptr and wraps.
module rr_pick3 (
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  input  logic [2:0] starved,
  output logic [2:0] pick
);

  logic [2:0] hungry;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    pick   = '0;
    hungry = req & starved;
    if (|hungry) begin
      if      (hungry[0]) pick = 3'b001;
      else if (hungry[1]) pick = 3'b010;
      else                pick = 3'b100;
    end else begin
      case (ptr)
        2'd0: begin
          if      (req[1]) pick = 3'b010;
          else if (req[2]) pick = 3'b100;
          else if (req[0]) pick = 3'b001;
        end
        2'd1: begin
          if      (req[2]) pick = 3'b100;
          else if (req[0]) pick = 3'b001;
          else if (req[1]) pick = 3'b010;
        end
        default: begin
          if      (req[0]) pick = 3'b001;
          else if (req[1]) pick = 3'b010;
          else if (req[2]) pick = 3'b100;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the register-file write port among
// writeback (0), load return (1) and the debug loader (2).
//   clk, rst   clock and synchronous active-high reset
//   stall      blocks all grants this cycle
//   req        per-requester write request, held until granted
//   addr/data  per-requester destination register and write data
//   lock       requester 2 takes the port exclusively while high
//   gnt        one-hot combinational grant
//   A3/WD3/WE3 registered write port, one cycle after the grant
//   locked     FSM is in LOCKED
//   starved    per-requester wait counter has reached WAIT_MAX
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int N        = 24,
  parameter int WAIT_MAX = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic [2:0]          req,
  input  logic [2:0][3:0]     addr,
  input  logic [2:0][N-1:0]   data,
  input  logic                lock,
  output logic [2:0]          gnt,
  output logic [3:0]          A3,
  output logic [N-1:0]        WD3,
  output logic                WE3,
  output logic                locked,
  output logic [2:0]          starved
);

  localparam logic [3:0] WAIT_SAT = 4'(WAIT_MAX);

  arb_state_t               state, state_nxt;
  logic [1:0]               ptr;
  logic [NUM_WR_REQ-1:0][3:0] cnt;
  logic                     arb_mode;
  logic [2:0]               elig;
  logic [2:0]               pick;
  logic [1:0]               gidx;
  logic                     do_write;

  // In LOCKED, the first cycle with lock low is already arbitrated normally.
  always_comb begin
    arb_mode  = (state == ARB) || !lock;
    elig      = '0;
    state_nxt = state;
    if (!stall) elig = arb_mode ? req : (req & 3'b100);
    if (arb_mode) state_nxt = (pick[REQ_DBG] && lock) ? LOCKED : ARB;
  end

  rr_pick3 u_pick (
    .req     (elig),
    .ptr     (ptr),
    .starved (starved),
    .pick    (pick)
  );

  for (genvar i = 0; i < NUM_WR_REQ; i++) begin : g_starved
    assign starved[i] = (cnt[i] == WAIT_SAT);
  end

  assign gnt      = pick;
  assign gidx     = onehot_to_idx(pick);
  assign locked   = (state == LOCKED);
  // The zero register is accepted but never written; REG_PC passes through.
  assign do_write = (|pick) && (addr[gidx] != REG_ZERO);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
      ptr   <= 2'd2;
      cnt   <= '0;
      A3    <= '0;
      WD3   <= '0;
      WE3   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (|pick) ptr <= gidx;
      for (int i = 0; i < NUM_WR_REQ; i++) begin
        if (!req[i] || pick[i])      cnt[i] <= '0;
        else if (cnt[i] != WAIT_SAT) cnt[i] <= cnt[i] + 4'd1;
      end
      WE3 <= do_write;
      if (do_write) begin
        A3  <= addr[gidx];
        WD3 <= data[gidx];
      end
    end
  end

endmodule
